// File: rtl/qproc_time_pkg.sv
// Package: qproc_time_pkg
// Shared types for the time-base command arbiter.
//   time_cmd_t    : 3-bit time command codes (0, 6 and 7 are illegal)
//   time_arb_st_t : arbiter sequencing FSM states
//   cmd_legal()   : true for the five codes that drive the time controller
package qproc_time_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_RST   = 3'd1,
        CMD_INIT  = 3'd2,
        CMD_UPDT  = 3'd3,
        CMD_START = 3'd4,
        CMD_STOP  = 3'd5
    } time_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } time_arb_st_t;

    function automatic logic cmd_legal(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

endpackage

// File: rtl/qproc_time_cmd_arb.sv
// Module: qproc_time_cmd_arb
// Arbitrates host and tProc core time-base commands (host has fixed priority) and
// turns each one into a stretched strobe / level on the t_clk time controller inputs.
// Every legal command holds its strobe for HOLD_CYC cycles, then keeps all strobes low
// for GAP_CYC cycles so the far-side edge detector re-arms and dt stays stable.
// Ports:
//   c_clk_i, c_rst_ni            clock, asynchronous active-low reset
//   host_cmd_vld_i/_i/dt_i/rdy_o host command channel (valid/ready)
//   core_cmd_vld_i/_i/dt_i/rdy_o core command channel (valid/ready), stalls behind host
//   err_clr_i                    clears the sticky illegal-command flag
//   c_time_rst/init/updt_o       registered strobes, one at a time, HOLD_CYC wide
//   c_time_en_o                  registered run level (START sets, STOP/RST clear)
//   c_offset_dt_o                offset, loaded only by INIT/UPDT accepts
//   busy_o, last_src_o, err_o    status: FSM busy, last source (1 host), sticky error
module qproc_time_cmd_arb
    import qproc_time_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic        c_clk_i,
    input  logic        c_rst_ni,
    input  logic        host_cmd_vld_i,
    input  logic [2:0]  host_cmd_i,
    input  logic [31:0] host_dt_i,
    output logic        host_cmd_rdy_o,
    input  logic        core_cmd_vld_i,
    input  logic [2:0]  core_cmd_i,
    input  logic [31:0] core_dt_i,
    output logic        core_cmd_rdy_o,
    input  logic        err_clr_i,
    output logic        c_time_rst_o,
    output logic        c_time_init_o,
    output logic        c_time_en_o,
    output logic        c_time_updt_o,
    output logic [31:0] c_offset_dt_o,
    output logic        busy_o,
    output logic        last_src_o,
    output logic        err_o
);

    localparam int unsigned MaxCyc = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    // Counter holds "cycles remaining after this one", so loads are N-1.
    localparam logic [CntW-1:0] HoldLd = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] GapLd  = CntW'(GAP_CYC - 1);

    time_arb_st_t    st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rst_q, rst_d;
    logic            init_q, init_d;
    logic            updt_q, updt_d;
    logic            en_q, en_d;
    logic [31:0]     dt_q, dt_d;
    logic            src_q, src_d;
    logic            err_q, err_d;

    logic            idle;
    logic            host_acc, core_acc, acc;
    logic [2:0]      acc_cmd;
    logic [31:0]     acc_dt;
    logic            acc_legal;

    // Arbitration: host wins; core only sees ready when host is not requesting.
    always_comb begin
        idle      = (st_q == ST_IDLE);
        host_acc  = idle & host_cmd_vld_i;
        core_acc  = idle & core_cmd_vld_i & ~host_cmd_vld_i;
        acc       = host_acc | core_acc;
        acc_cmd   = host_acc ? host_cmd_i : core_cmd_i;
        acc_dt    = host_acc ? host_dt_i : core_dt_i;
        acc_legal = cmd_legal(acc_cmd);
    end

    // State register
    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            rst_q  <= 1'b0;
            init_q <= 1'b0;
            updt_q <= 1'b0;
            en_q   <= 1'b0;
            dt_q   <= '0;
            src_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rst_q  <= rst_d;
            init_q <= init_d;
            updt_q <= updt_d;
            en_q   <= en_d;
            dt_q   <= dt_d;
            src_q  <= src_d;
            err_q  <= err_d;
        end
    end

    // Next-state and counter
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE:  if (acc && acc_legal) st_d = ST_ISSUE;
            ST_ISSUE: if (cnt_q == '0) st_d = ST_GAP;
            ST_GAP:   if (cnt_q == '0) st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if (st_d != st_q) begin
            unique case (st_d)
                ST_ISSUE: cnt_d = HoldLd;
                ST_GAP:   cnt_d = GapLd;
                default:  cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Output register next values
    always_comb begin
        rst_d  = rst_q;
        init_d = init_q;
        updt_d = updt_q;
        en_d   = en_q;
        dt_d   = dt_q;
        src_d  = src_q;
        err_d  = err_q;

        if (err_clr_i) err_d = 1'b0;

        if (idle && acc) begin
            src_d = host_acc;
            if (!acc_legal) begin
                // Illegal code still completes the handshake; set beats clear.
                err_d = 1'b1;
            end else begin
                case (time_cmd_t'(acc_cmd))
                    CMD_RST: begin
                        rst_d = 1'b1;
                        en_d  = 1'b0;
                    end
                    CMD_INIT: begin
                        init_d = 1'b1;
                        dt_d   = acc_dt;
                    end
                    CMD_UPDT: begin
                        updt_d = 1'b1;
                        dt_d   = acc_dt;
                    end
                    CMD_START: en_d = 1'b1;
                    CMD_STOP:  en_d = 1'b0;
                    default:   ;
                endcase
            end
        end else if (st_q == ST_ISSUE && st_d == ST_GAP) begin
            rst_d  = 1'b0;
            init_d = 1'b0;
            updt_d = 1'b0;
        end
    end

    always_comb begin
        host_cmd_rdy_o = idle;
        core_cmd_rdy_o = idle & ~host_cmd_vld_i;
        c_time_rst_o   = rst_q;
        c_time_init_o  = init_q;
        c_time_updt_o  = updt_q;
        c_time_en_o    = en_q;
        c_offset_dt_o  = dt_q;
        busy_o         = ~idle;
        last_src_o     = src_q;
        err_o          = err_q;
    end

endmodule

// File: tb/tb_qproc_time_cmd_arb.sv
module tb_qproc_time_cmd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_vld, core_vld;
    logic [2:0]  host_cmd, core_cmd;
    logic [31:0] host_dt, core_dt;
    logic        host_rdy, core_rdy;
    logic        err_clr;
    logic        t_rst, t_init, t_en, t_updt;
    logic [31:0] t_dt;
    logic        busy, last_src, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qproc_time_cmd_arb #(
        .HOLD_CYC(4),
        .GAP_CYC (4)
    ) dut (
        .c_clk_i       (clk),
        .c_rst_ni      (rst_n),
        .host_cmd_vld_i(host_vld),
        .host_cmd_i    (host_cmd),
        .host_dt_i     (host_dt),
        .host_cmd_rdy_o(host_rdy),
        .core_cmd_vld_i(core_vld),
        .core_cmd_i    (core_cmd),
        .core_dt_i     (core_dt),
        .core_cmd_rdy_o(core_rdy),
        .err_clr_i     (err_clr),
        .c_time_rst_o  (t_rst),
        .c_time_init_o (t_init),
        .c_time_en_o   (t_en),
        .c_time_updt_o (t_updt),
        .c_offset_dt_o (t_dt),
        .busy_o        (busy),
        .last_src_o    (last_src),
        .err_o         (err)
    );

    typedef struct packed {
        logic        rst;
        logic        init;
        logic        en;
        logic        updt;
        logic        busy;
        logic        err;
        logic        src;
        logic [31:0] dt;
    } obs_t;

    typedef struct {
        logic        src;
        logic [2:0]  cmd;
        logic [31:0] dt;
        logic        exp_en;
        logic [31:0] exp_dt;
        logic        exp_err;
    } vec_t;

    obs_t        exp_q[$];
    logic        m_en, m_err;
    logic [31:0] m_dt;
    vec_t        vecs[10];

    function automatic obs_t observe();
        observe = {t_rst, t_init, t_en, t_updt, busy, err, last_src, t_dt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs from the cycle after accept, derived from the command timeline.
    task automatic push_exp(input logic src, input logic [2:0] cmd, input logic [31:0] dt);
        obs_t o;
        if (cmd == 3'd0 || cmd > 3'd5) begin
            m_err = 1'b1;
            o = {1'b0, 1'b0, m_en, 1'b0, 1'b0, m_err, src, m_dt};
            exp_q.push_back(o);
            return;
        end
        if (cmd == 3'd1 || cmd == 3'd5) m_en = 1'b0;
        if (cmd == 3'd4) m_en = 1'b1;
        if (cmd == 3'd2 || cmd == 3'd3) m_dt = dt;
        for (int i = 0; i < 4; i++) begin
            o = {cmd == 3'd1, cmd == 3'd2, m_en, cmd == 3'd3, 1'b1, m_err, src, m_dt};
            exp_q.push_back(o);
        end
        for (int i = 0; i < 4; i++) begin
            o = {1'b0, 1'b0, m_en, 1'b0, 1'b1, m_err, src, m_dt};
            exp_q.push_back(o);
        end
    endtask

    task automatic drain(input string name);
        obs_t e;
        int   k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_cyc%0d", name, k + 1), 64'(observe()), 64'(e));
            k++;
            tick();
        end
    endtask

    task automatic issue(input logic src, input logic [2:0] cmd, input logic [31:0] dt,
                         input string name);
        int n = 0;
        if (src) begin
            host_vld = 1'b1; host_cmd = cmd; host_dt = dt;
        end else begin
            core_vld = 1'b1; core_cmd = cmd; core_dt = dt;
        end
        while (!(src ? host_rdy : core_rdy) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_rdy_timeout: got rdy 0 expected rdy 1 within 50 cycles", name);
            host_vld = 1'b0;
            core_vld = 1'b0;
            return;
        end
        tick();
        host_vld = 1'b0;
        core_vld = 1'b0;
        err_clr  = 1'b0;
        push_exp(src, cmd, dt);
        drain(name);
        check({name, "_idle"}, 64'({host_rdy, core_rdy, busy}), 64'(3'b110));
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd2, 32'h0000_1000, 1'b0, 32'h0000_1000, 1'b0};
        vecs[1] = '{1'b0, 3'd4, 32'h0000_AAAA, 1'b1, 32'h0000_1000, 1'b0};
        vecs[2] = '{1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 3'd2, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b0};
        vecs[4] = '{1'b1, 3'd5, 32'h0000_0055, 1'b0, 32'h0000_0002, 1'b0};
        vecs[5] = '{1'b0, 3'd4, 32'h0000_0000, 1'b1, 32'h0000_0002, 1'b0};
        vecs[6] = '{1'b1, 3'd1, 32'h0000_0077, 1'b0, 32'h0000_0002, 1'b0};
        vecs[7] = '{1'b0, 3'd7, 32'h0000_0099, 1'b0, 32'h0000_0002, 1'b1};
        vecs[8] = '{1'b1, 3'd6, 32'h0000_0011, 1'b0, 32'h0000_0002, 1'b1};
        vecs[9] = '{1'b0, 3'd0, 32'h0000_0022, 1'b0, 32'h0000_0002, 1'b1};

        rst_n = 1'b0;
        host_vld = 1'b0; host_cmd = '0; host_dt = '0;
        core_vld = 1'b0; core_cmd = '0; core_dt = '0;
        err_clr = 1'b0;
        m_en = 1'b0; m_err = 1'b0; m_dt = '0;

        repeat (2) tick();
        check("reset_outputs", 64'(observe()), 64'(0));
        rst_n = 1'b1;
        tick();
        check("reset_rdy", 64'({host_rdy, core_rdy, busy}), 64'(3'b110));

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].src, vecs[i].cmd, vecs[i].dt, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_state", i), 64'({t_en, err, t_dt}),
                  64'({vecs[i].exp_en, vecs[i].exp_err, vecs[i].exp_dt}));
        end

        // Sticky error clear
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 1'b0;
        check("err_clr", 64'(err), 64'(0));

        // Host START and core UPDT together: host wins, core stalls then goes at idle
        host_vld = 1'b1; host_cmd = 3'd4; host_dt = 32'h0;
        core_vld = 1'b1; core_cmd = 3'd3; core_dt = 32'h5;
        #1;
        check("prio_rdy", 64'({host_rdy, core_rdy}), 64'(2'b10));
        tick();
        host_vld = 1'b0;
        check("prio_core_stall", 64'(core_rdy), 64'(0));
        push_exp(1'b1, 3'd4, 32'h0);
        drain("prio_host");
        check("prio_core_rdy", 64'(core_rdy), 64'(1));
        tick();
        core_vld = 1'b0;
        push_exp(1'b0, 3'd3, 32'h5);
        drain("prio_core");
        check("prio_state", 64'({t_en, t_dt}), 64'({1'b1, 32'h5}));

        // Back-to-back UPDTs: each accepted the cycle the FSM returns to idle
        for (int i = 1; i <= 3; i++) begin
            issue(1'b1, 3'd3, 32'(i), $sformatf("b2b%0d", i));
        end

        // Illegal accept with clear in the same cycle: set wins
        err_clr = 1'b1;
        issue(1'b0, 3'd7, 32'h0, "err_set_wins");
        check("err_set_wins_after", 64'(err), 64'(1));

        // Reset asserted mid-strobe
        host_vld = 1'b1; host_cmd = 3'd2; host_dt = 32'h1234_5678;
        tick();
        host_vld = 1'b0;
        check("rst_mid_init_high", 64'(t_init), 64'(1));
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(observe()), 64'(0));
        tick();
        rst_n = 1'b1;
        m_en = 1'b0; m_err = 1'b0; m_dt = '0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rst_release_cyc%0d", i), 64'(observe()), 64'(0));
            tick();
        end
        check("rst_release_rdy", 64'({host_rdy, core_rdy}), 64'(2'b11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
